rs_age_select: RTL
==================

Name: rs_age_select

Overview:
- Parametrised, out-of-order reservation station for the R10K core.
- Sits between rename/dispatch and the issue/execute registers.
- Accepts up to DISP_W renamed instructions per cycle and wakes operands from CDB_W completion broadcasts.
- Issues up to ISSUE_W ready instructions per cycle, oldest first via an age matrix. Supports execute back-pressure and a full flush on mispredict.

Parameters:
- DEPTH, 16: number of entries (power of 2, >= 4).
- DISP_W, 2: dispatch slots per cycle.
- ISSUE_W, 2: issue slots per cycle.
- CDB_W, 2: completion broadcasts per cycle.
- TAG_W, 6: physical register tag width. Tag 0 is the hardwired zero register and is always ready.
- PAYLOAD_W, 64: opaque instruction payload (inst, PC, NPC, control) carried to issue.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- disp_valid  in  DISP_W  per-slot dispatch request; slot 0 is oldest
- disp_src1_tag  in  DISP_W*TAG_W  source-1 physical tag
- disp_src1_rdy  in  DISP_W  source-1 ready at rename
- disp_src2_tag  in  DISP_W*TAG_W  source-2 physical tag
- disp_src2_rdy  in  DISP_W  source-2 ready at rename
- disp_dest_tag  in  DISP_W*TAG_W  destination physical tag
- disp_payload  in  DISP_W*PAYLOAD_W  payload per slot
- disp_accept  out  DISP_W  combinational; slot written this cycle
- free_count  out  $clog2(DEPTH)+1  registered count of free entries
- cdb_valid  in  CDB_W  completion broadcast valid
- cdb_tag  in  CDB_W*TAG_W  completing destination tag
- issue_stall  in  1  execute cannot accept; hold issue outputs
- flush  in  1  mispredict squash of all entries
- issue_valid  out  ISSUE_W  registered issue slot valid
- issue_dest_tag  out  ISSUE_W*TAG_W  registered destination tag
- issue_payload  out  ISSUE_W*PAYLOAD_W  registered payload

Behaviour:
- Reset:
  - All entries invalid; age matrix cleared.
  - issue_valid = 0; issue_dest_tag = 0; issue_payload = 0; free_count = DEPTH.
- Dispatch acceptance:
  - disp_accept[i] = disp_valid[i] && !flush && (popcount of disp_valid[0..i]) <= free_count.
  - Accepted slots are written to the lowest-index free entries, in slot order.
- Age ordering:
  - A new entry is younger than every occupied entry.
  - Among same-cycle dispatches, lower slot is older.
  - Age matrix row set on allocate; column cleared on free.
- Wakeup:
  - At dispatch: a source is ready if disp_srcN_rdy, or tag == 0, or its tag matches any valid cdb_tag in the same cycle (bypass).
  - Stored entries: a source ready bit sets at the edge when its tag matches any valid cdb_tag.
- Select (when !issue_stall):
  - Eligible = valid && (src1 ready || src1 CDB match this cycle) && (src2 ready || src2 CDB match this cycle). Wakeup and select happen in the same cycle.
  - Entries written this cycle are not eligible.
  - Pick up to ISSUE_W oldest eligible entries. Slot 0 gets the oldest; unused slots get issue_valid = 0.
  - Selected entries are freed at the edge.
- Issue latency:
  - Dispatch with ready operands at cycle t -> issue_valid at t+2.
  - Stored waiting entry with matching CDB at t -> issue_valid at t+1.
- issue_stall = 1: issue registers hold their values, no selection, no entry freed. Dispatch and wakeup continue.
- flush = 1 (wins over all other inputs):
  - Next cycle: all entries invalid, issue_valid = 0, free_count = DEPTH.
  - Dispatch and CDB are ignored that cycle; disp_accept = 0.
- Simultaneous dispatch and issue in one cycle: freed entries are not reused until the next cycle. free_count after the edge = previous free_count - accepted + issued.
- Full: free_count = 0 -> disp_accept = 0. Issue still proceeds.
- Duplicate CDB tags in one cycle are legal and idempotent.

Test Plan:
- Reset, then dispatch 2 slots with all sources ready (dest 7, 8) at cycle 1 -> free_count = 14 at cycle 2. Cycle 3: issue_valid = 2'b11, dest 7 in slot 0, dest 8 in slot 1. Cycle 4: free_count = 16.
- Dispatch an entry waiting on src1 = 5, then 3 idle cycles, then cdb_tag = 5 at cycle t -> issue_valid[0] = 1 with its dest at t+1.
- Dispatch with src2 = 9 not ready while cdb_tag = 9 in the same cycle -> entry stored ready; issues 2 cycles later.
- Fill all 16 entries waiting on tag 3; disp_valid = 2'b11 -> disp_accept = 0. Broadcast 3 -> the two oldest issue in order, one per slot, and free_count rises by 2 each cycle.
- Hold issue_stall = 1 for 3 cycles with 4 ready entries -> issue outputs frozen and free_count unchanged. Stall release -> the next two oldest issue.
- flush with 10 occupied entries plus a same-cycle dispatch and CDB -> disp_accept = 0, next cycle issue_valid = 0 and free_count = 16. No later issue of the squashed tags.

Source files
------------

// File: rtl/rs_age_select.sv
// Out-of-order reservation station: holds renamed instructions until both sources
//    are ready, then issues the oldest ready ones (age matrix) into the issue registers.
// Latency: ready dispatch at t -> issue_valid at t+2; stored entry woken by the CDB at t -> t+1.
// Backpressure: issue_stall freezes the issue registers and frees nothing; dispatch is
//    throttled by disp_accept against the registered free_count. flush squashes everything.
// Ports:
//    clock, reset                   : clock, synchronous active-high reset
//    disp_*                         : DISP_W dispatch slots (slot 0 oldest), disp_accept back
//    free_count                     : registered number of free entries
//    cdb_valid, cdb_tag             : CDB_W completion broadcasts (operand wakeup)
//    issue_stall, flush             : execute back-pressure, mispredict squash
//    issue_valid/dest_tag/payload   : ISSUE_W registered issue slots (slot 0 oldest)
module rs_age_select #(
   parameter int DEPTH     = 16,
   parameter int DISP_W    = 2,
   parameter int ISSUE_W   = 2,
   parameter int CDB_W     = 2,
   parameter int TAG_W     = 6,
   parameter int PAYLOAD_W = 64
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic [DISP_W-1:0]            disp_valid,
   input  logic [DISP_W*TAG_W-1:0]      disp_src1_tag,
   input  logic [DISP_W-1:0]            disp_src1_rdy,
   input  logic [DISP_W*TAG_W-1:0]      disp_src2_tag,
   input  logic [DISP_W-1:0]            disp_src2_rdy,
   input  logic [DISP_W*TAG_W-1:0]      disp_dest_tag,
   input  logic [DISP_W*PAYLOAD_W-1:0]  disp_payload,
   output logic [DISP_W-1:0]            disp_accept,
   output logic [$clog2(DEPTH):0]       free_count,
   input  logic [CDB_W-1:0]             cdb_valid,
   input  logic [CDB_W*TAG_W-1:0]       cdb_tag,
   input  logic                         issue_stall,
   input  logic                         flush,
   output logic [ISSUE_W-1:0]           issue_valid,
   output logic [ISSUE_W*TAG_W-1:0]     issue_dest_tag,
   output logic [ISSUE_W*PAYLOAD_W-1:0] issue_payload
);

   localparam int CNT_W = $clog2(DEPTH) + 1;

   // ---------------------------------------------------------------------------
   // Entry state
   // ---------------------------------------------------------------------------
   logic [DEPTH-1:0]     valid_q, valid_d;
   logic [DEPTH-1:0]     s1_rdy_q, s1_rdy_d;
   logic [DEPTH-1:0]     s2_rdy_q, s2_rdy_d;
   logic [TAG_W-1:0]     s1_tag_q  [DEPTH];
   logic [TAG_W-1:0]     s2_tag_q  [DEPTH];
   logic [TAG_W-1:0]     dest_q    [DEPTH];
   logic [PAYLOAD_W-1:0] payload_q [DEPTH];
   // age_q[e][j] = 1 means entry e is younger than entry j.
   logic [DEPTH-1:0]     age_q [DEPTH];
   logic [DEPTH-1:0]     age_d [DEPTH];
   logic [CNT_W-1:0]     free_cnt_q, free_cnt_d;

   logic [ISSUE_W-1:0]           issue_valid_q;
   logic [ISSUE_W*TAG_W-1:0]     issue_dest_q;
   logic [ISSUE_W*PAYLOAD_W-1:0] issue_payload_q;

   // ---------------------------------------------------------------------------
   // Wakeup: CDB tag compare against stored sources and incoming dispatch sources
   // ---------------------------------------------------------------------------
   logic [DEPTH-1:0]  s1_hit, s2_hit;
   logic [DISP_W-1:0] d1_rdy, d2_rdy;

   always_comb begin
      s1_hit = '0;
      s2_hit = '0;
      d1_rdy = disp_src1_rdy;
      d2_rdy = disp_src2_rdy;
      // Tag 0 is the hardwired zero register.
      for (int i = 0; i < DISP_W; i++) begin
         if (disp_src1_tag[i*TAG_W +: TAG_W] == '0) d1_rdy[i] = 1'b1;
         if (disp_src2_tag[i*TAG_W +: TAG_W] == '0) d2_rdy[i] = 1'b1;
      end
      for (int c = 0; c < CDB_W; c++) begin
         if (cdb_valid[c]) begin
            for (int e = 0; e < DEPTH; e++) begin
               if (s1_tag_q[e] == cdb_tag[c*TAG_W +: TAG_W]) s1_hit[e] = 1'b1;
               if (s2_tag_q[e] == cdb_tag[c*TAG_W +: TAG_W]) s2_hit[e] = 1'b1;
            end
            // Same-cycle bypass into the entry being written.
            for (int i = 0; i < DISP_W; i++) begin
               if (disp_src1_tag[i*TAG_W +: TAG_W] == cdb_tag[c*TAG_W +: TAG_W]) d1_rdy[i] = 1'b1;
               if (disp_src2_tag[i*TAG_W +: TAG_W] == cdb_tag[c*TAG_W +: TAG_W]) d2_rdy[i] = 1'b1;
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Select: repeatedly take the eligible entry that is younger than no other
   // eligible entry. Only already-stored entries can be eligible, so entries
   // written this cycle are naturally excluded.
   // ---------------------------------------------------------------------------
   logic [DEPTH-1:0]             eligible;
   logic [DEPTH-1:0]             sel_oh [ISSUE_W];
   logic [ISSUE_W-1:0]           sel_vld;
   logic [ISSUE_W*TAG_W-1:0]     sel_dest;
   logic [ISSUE_W*PAYLOAD_W-1:0] sel_payload;
   logic [DEPTH-1:0]             free_mask;
   logic [CNT_W-1:0]             n_iss;

   assign eligible = valid_q & (s1_rdy_q | s1_hit) & (s2_rdy_q | s2_hit)
                   & {DEPTH{~issue_stall & ~flush}};

   always_comb begin : p_select
      logic [DEPTH-1:0] cand;
      cand        = eligible;
      sel_vld     = '0;
      sel_dest    = '0;
      sel_payload = '0;
      free_mask   = '0;
      n_iss       = '0;
      for (int s = 0; s < ISSUE_W; s++) begin
         sel_oh[s] = '0;
         for (int e = 0; e < DEPTH; e++) begin
            if (cand[e] && ((age_q[e] & cand) == '0)) sel_oh[s][e] = 1'b1;
         end
         for (int e = 0; e < DEPTH; e++) begin
            if (sel_oh[s][e]) begin
               sel_dest[s*TAG_W +: TAG_W]            = dest_q[e];
               sel_payload[s*PAYLOAD_W +: PAYLOAD_W] = payload_q[e];
            end
         end
         sel_vld[s] = |sel_oh[s];
         if (sel_vld[s]) n_iss = n_iss + CNT_W'(1);
         free_mask = free_mask | sel_oh[s];
         cand      = cand & ~sel_oh[s];
      end
   end

   // ---------------------------------------------------------------------------
   // Dispatch acceptance and allocation. Accepted slots always form a prefix of
   // the requesting slots, so the k-th accepted slot takes the k-th lowest free
   // entry. Entries freed by this cycle's issue are not visible here (valid_q).
   // ---------------------------------------------------------------------------
   logic [DEPTH-1:0] alloc_oh [DISP_W];
   logic [CNT_W-1:0] n_acc;

   always_comb begin : p_alloc
      logic [CNT_W-1:0] req_cnt;
      logic [DEPTH-1:0] taken;
      logic             found;
      req_cnt     = '0;
      taken       = '0;
      found       = 1'b0;
      n_acc       = '0;
      disp_accept = '0;
      for (int i = 0; i < DISP_W; i++) begin
         alloc_oh[i] = '0;
         if (disp_valid[i]) req_cnt = req_cnt + CNT_W'(1);
         disp_accept[i] = disp_valid[i] && !flush && (req_cnt <= free_cnt_q);
         if (disp_accept[i]) begin
            n_acc = n_acc + CNT_W'(1);
            found = 1'b0;
            for (int e = 0; e < DEPTH; e++) begin
               if (!found && !valid_q[e] && !taken[e]) begin
                  found          = 1'b1;
                  alloc_oh[i][e] = 1'b1;
               end
            end
            taken = taken | alloc_oh[i];
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Next state: free issued entries (clearing their age column), wake stored
   // sources, then write new entries. A new entry's row marks it younger than
   // every surviving entry and every lower dispatch slot of this cycle.
   // ---------------------------------------------------------------------------
   always_comb begin : p_next
      logic [DEPTH-1:0] older_new;
      older_new = '0;
      valid_d   = valid_q & ~free_mask;
      s1_rdy_d  = s1_rdy_q | s1_hit;
      s2_rdy_d  = s2_rdy_q | s2_hit;
      for (int r = 0; r < DEPTH; r++) age_d[r] = age_q[r] & ~free_mask;
      for (int i = 0; i < DISP_W; i++) begin
         for (int e = 0; e < DEPTH; e++) begin
            if (alloc_oh[i][e]) begin
               valid_d[e]  = 1'b1;
               s1_rdy_d[e] = d1_rdy[i];
               s2_rdy_d[e] = d2_rdy[i];
               age_d[e]    = (valid_q & ~free_mask) | older_new;
            end
         end
         older_new = older_new | alloc_oh[i];
      end
      if (flush) begin
         valid_d = '0;
         for (int r = 0; r < DEPTH; r++) age_d[r] = '0;
      end
      free_cnt_d = flush ? CNT_W'(DEPTH) : (free_cnt_q - n_acc + n_iss);
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) begin
         valid_q         <= '0;
         s1_rdy_q        <= '0;
         s2_rdy_q        <= '0;
         free_cnt_q      <= CNT_W'(DEPTH);
         for (int r = 0; r < DEPTH; r++) age_q[r] <= '0;
         issue_valid_q   <= '0;
         issue_dest_q    <= '0;
         issue_payload_q <= '0;
      end else begin
         valid_q    <= valid_d;
         s1_rdy_q   <= s1_rdy_d;
         s2_rdy_q   <= s2_rdy_d;
         free_cnt_q <= free_cnt_d;
         for (int r = 0; r < DEPTH; r++) age_q[r] <= age_d[r];
         if (flush) begin
            issue_valid_q <= '0;
         end else if (!issue_stall) begin
            issue_valid_q   <= sel_vld;
            issue_dest_q    <= sel_dest;
            issue_payload_q <= sel_payload;
         end
      end
   end

   // Entry fields are qualified by valid_q, so they need no reset.
   always_ff @(posedge clock) begin
      for (int e = 0; e < DEPTH; e++) begin
         for (int i = 0; i < DISP_W; i++) begin
            if (alloc_oh[i][e]) begin
               s1_tag_q[e]  <= disp_src1_tag[i*TAG_W +: TAG_W];
               s2_tag_q[e]  <= disp_src2_tag[i*TAG_W +: TAG_W];
               dest_q[e]    <= disp_dest_tag[i*TAG_W +: TAG_W];
               payload_q[e] <= disp_payload[i*PAYLOAD_W +: PAYLOAD_W];
            end
         end
      end
   end

   assign free_count     = free_cnt_q;
   assign issue_valid    = issue_valid_q;
   assign issue_dest_tag = issue_dest_q;
   assign issue_payload  = issue_payload_q;

endmodule
